global_history_register: RTL and testbench

//  Speculative global branch history (GHR) that indexes PatternHistoryTable in IF.
//  - Shifts in predicted directions of each fetched group.
//  - Hands every slot its pre-shift history as a checkpoint.
//  - Restores the GHR on a BSC mispredict repair or a commit-side exception flush.
//  - Keeps an architectural copy that is updated at retire.

---
 rtl/global_history_register_pkg.sv | 40 ++++
 rtl/global_history_register_if.sv | 39 +++
 rtl/global_history_register_group_shift.sv | 33 +++
 rtl/global_history_register.sv | 82 ++++++++
 tb/tb_global_history_register.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/global_history_register_pkg.sv
// Shared types and helpers for the speculative/architectural global branch history.
// All widths derive from HIST_LEN and FETCH_W; the group shifter is written for FETCH_W == 4.
package global_history_register_pkg;

  localparam int HIST_LEN = 8;
  localparam int FETCH_W  = 4;

  typedef logic [HIST_LEN-1:0] hist_t;
  typedef logic [FETCH_W-1:0]  slot_mask_t;

  // Packed so that slot i lands at [i*HIST_LEN +: HIST_LEN] when flattened.
  typedef logic [FETCH_W-1:0][HIST_LEN-1:0] slot_hist_t;

  typedef struct packed {
    slot_mask_t valid;
    slot_mask_t is_cond;
    slot_mask_t is_jump;
    slot_mask_t pred_take;
  } fetch_grp_t;

  typedef struct packed {
    logic  vld;
    hist_t ckpt;
    logic  is_cond;
    logic  correct_take;
  } repair_t;

  typedef struct packed {
    logic vld;
    logic is_cond;
    logic take;
    logic flush;
  } commit_t;

  // Oldest bit falls off the MSB end; no saturation.
  function automatic hist_t hist_shift(input hist_t h, input logic b);
    return {h[HIST_LEN-2:0], b};
  endfunction

endpackage

// File: rtl/global_history_register_if.sv
// Fetch, repair, commit and history-output signals of the GHR block.
// master drives requests and observes history; slave is the GHR itself.
interface global_history_register_if;
  import global_history_register_pkg::*;

  logic                        inst_index_ok;
  logic                        inst_req;
  logic [FETCH_W-1:0]          PRD_slotValid_i;
  logic [FETCH_W-1:0]          PRD_slotIsCond_i;
  logic [FETCH_W-1:0]          PRD_slotIsJump_i;
  logic [FETCH_W-1:0]          PHT_predTake_p_i;
  logic [HIST_LEN-1:0]         GHR_history_o;
  logic [FETCH_W*HIST_LEN-1:0] GHR_slotHist_p_o;
  logic                        BSC_repair_w_i;
  logic [HIST_LEN-1:0]         BSC_ckptHist_w_i;
  logic                        BSC_isCond_w_i;
  logic                        BSC_correctTake_w_i;
  logic                        CMT_valid_i;
  logic                        CMT_isCond_i;
  logic                        CMT_take_i;
  logic                        CMT_flush_i;

  modport master (
    output inst_index_ok, inst_req,
    output PRD_slotValid_i, PRD_slotIsCond_i, PRD_slotIsJump_i, PHT_predTake_p_i,
    output BSC_repair_w_i, BSC_ckptHist_w_i, BSC_isCond_w_i, BSC_correctTake_w_i,
    output CMT_valid_i, CMT_isCond_i, CMT_take_i, CMT_flush_i,
    input  GHR_history_o, GHR_slotHist_p_o
  );

  modport slave (
    input  inst_index_ok, inst_req,
    input  PRD_slotValid_i, PRD_slotIsCond_i, PRD_slotIsJump_i, PHT_predTake_p_i,
    input  BSC_repair_w_i, BSC_ckptHist_w_i, BSC_isCond_w_i, BSC_correctTake_w_i,
    input  CMT_valid_i, CMT_isCond_i, CMT_take_i, CMT_flush_i,
    output GHR_history_o, GHR_slotHist_p_o
  );

endinterface

// File: rtl/global_history_register_group_shift.sv
// Combinational per-slot history chain for one fetch group, stopping at the first taken cond or jump.
// Zero latency; no flow control (pure function of the current history and slot flags).
module ghr_group_shift
  import global_history_register_pkg::*;
(
  input  hist_t      spec_hist,
  input  fetch_grp_t grp,
  output slot_hist_t slot_hist,
  output hist_t      next_hist
);

  always_comb begin
    hist_t h;
    logic  live;
    h         = spec_hist;
    live      = 1'b1;
    slot_hist = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      slot_hist[i] = h;
      if (live && grp.valid[i]) begin
        if (grp.is_cond[i]) begin
          h = hist_shift(h, grp.pred_take[i]);
        end
        // A redirect ends the group: younger slots inherit the post-redirect history unchanged.
        if ((grp.is_cond[i] && grp.pred_take[i]) || grp.is_jump[i]) begin
          live = 1'b0;
        end
      end
    end
    next_hist = h;
  end

endmodule

// File: rtl/global_history_register.sv
// Speculative GHR with per-slot checkpoints plus a retire-updated architectural copy.
// Updates visible one cycle after fire/repair/flush/retire; never stalls fetch.
module global_history_register
  import global_history_register_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  global_history_register_if.slave  bus
);

  hist_t      spec_ghr_q, spec_ghr_d;
  hist_t      arch_ghr_q, arch_ghr_d;
  hist_t      grp_next_hist;
  slot_hist_t grp_slot_hist;
  fetch_grp_t grp;
  repair_t    rep;
  commit_t    cmt;
  logic       fire;

  assign fire = bus.inst_index_ok & bus.inst_req;

  assign grp = '{
    valid:     bus.PRD_slotValid_i,
    is_cond:   bus.PRD_slotIsCond_i,
    is_jump:   bus.PRD_slotIsJump_i,
    pred_take: bus.PHT_predTake_p_i
  };

  assign rep = '{
    vld:          bus.BSC_repair_w_i,
    ckpt:         bus.BSC_ckptHist_w_i,
    is_cond:      bus.BSC_isCond_w_i,
    correct_take: bus.BSC_correctTake_w_i
  };

  assign cmt = '{
    vld:     bus.CMT_valid_i,
    is_cond: bus.CMT_isCond_i,
    take:    bus.CMT_take_i,
    flush:   bus.CMT_flush_i
  };

  ghr_group_shift u_group_shift (
    .spec_hist (spec_ghr_q),
    .grp       (grp),
    .slot_hist (grp_slot_hist),
    .next_hist (grp_next_hist)
  );

  always_comb begin
    arch_ghr_d = arch_ghr_q;
    if (cmt.vld && cmt.is_cond) begin
      arch_ghr_d = hist_shift(arch_ghr_q, cmt.take);
    end
  end

  // Flush restores from arch_ghr_d so a branch retiring in the flush cycle is not lost.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (cmt.flush) begin
      spec_ghr_d = arch_ghr_d;
    end else if (rep.vld) begin
      spec_ghr_d = rep.is_cond ? hist_shift(rep.ckpt, rep.correct_take) : rep.ckpt;
    end else if (fire) begin
      spec_ghr_d = grp_next_hist;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      arch_ghr_q <= arch_ghr_d;
    end
  end

  assign bus.GHR_history_o    = spec_ghr_q;
  assign bus.GHR_slotHist_p_o = grp_slot_hist;

endmodule

// File: tb/tb_global_history_register.sv
// Scoreboarded bench for global_history_register: directed scenarios plus a random mix.
module tb_global_history_register;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  global_history_register_if bus_if ();

  global_history_register dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  logic [7:0] mdl_spec = 8'h00;
  logic [7:0] mdl_arch = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: find where the group terminates, then walk only the surviving slots.
  task automatic ref_group(input logic [7:0] g, input logic [3:0] v, c, j, t,
                           output logic [31:0] slots, output logic [7:0] nxt);
    int last;
    logic [7:0] cur;
    last = 3;
    for (int k = 3; k >= 0; k--)
      if (v[k] && ((c[k] && t[k]) || j[k])) last = k;
    cur = g;
    slots = '0;
    for (int k = 0; k < 4; k++) begin
      slots[k*8 +: 8] = cur;
      if (k <= last && v[k] && c[k]) cur = {cur[6:0], t[k]};
    end
    nxt = cur;
  endtask

  task automatic idle_inputs();
    bus_if.inst_index_ok       = 1'b0;
    bus_if.inst_req            = 1'b0;
    bus_if.PRD_slotValid_i     = '0;
    bus_if.PRD_slotIsCond_i    = '0;
    bus_if.PRD_slotIsJump_i    = '0;
    bus_if.PHT_predTake_p_i    = '0;
    bus_if.BSC_repair_w_i      = 1'b0;
    bus_if.BSC_ckptHist_w_i    = '0;
    bus_if.BSC_isCond_w_i      = 1'b0;
    bus_if.BSC_correctTake_w_i = 1'b0;
    bus_if.CMT_valid_i         = 1'b0;
    bus_if.CMT_isCond_i        = 1'b0;
    bus_if.CMT_take_i          = 1'b0;
    bus_if.CMT_flush_i         = 1'b0;
  endtask

  // One cycle: drive at negedge, push expected history, check it #1 after the posedge.
  task automatic step(input string tag, input logic ok, req, input logic [3:0] v, c, j, t,
                      input logic rep, input logic [7:0] ck, input logic rc, rt,
                      input logic cv, cc, ct, cf);
    logic [31:0] slots;
    logic [7:0]  nxt, arch_n;
    @(negedge clk);
    bus_if.inst_index_ok       = ok;
    bus_if.inst_req            = req;
    bus_if.PRD_slotValid_i     = v;
    bus_if.PRD_slotIsCond_i    = c;
    bus_if.PRD_slotIsJump_i    = j;
    bus_if.PHT_predTake_p_i    = t;
    bus_if.BSC_repair_w_i      = rep;
    bus_if.BSC_ckptHist_w_i    = ck;
    bus_if.BSC_isCond_w_i      = rc;
    bus_if.BSC_correctTake_w_i = rt;
    bus_if.CMT_valid_i         = cv;
    bus_if.CMT_isCond_i        = cc;
    bus_if.CMT_take_i          = ct;
    bus_if.CMT_flush_i         = cf;
    ref_group(mdl_spec, v, c, j, t, slots, nxt);
    #1;
    chk({tag, ".slots"}, bus_if.GHR_slotHist_p_o, slots);
    arch_n = (cv && cc) ? {mdl_arch[6:0], ct} : mdl_arch;
    if (cf)              mdl_spec = arch_n;
    else if (rep)        mdl_spec = rc ? {ck[6:0], rt} : ck;
    else if (ok && req)  mdl_spec = nxt;
    mdl_arch = arch_n;
    exp_q.push_back(mdl_spec);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    chk({tag_q.pop_front(), ".ghr"}, {24'h0, bus_if.GHR_history_o}, {24'h0, exp_q.pop_front()});
    idle_inputs();
  endtask

  task automatic set_spec(input logic [7:0] h);
    step("load", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, h, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic retire(input logic tk);
    step("retire", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0,
         1'b1, 1'b1, tk, 1'b0);
  endtask

  initial begin
    logic [7:0] arch_pat;
    idle_inputs();
    #1;
    chk("reset.ghr", {24'h0, bus_if.GHR_history_o}, 32'h0);
    chk("reset.slots", bus_if.GHR_slotHist_p_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Taken cond in slot 1 ends the group.
    set_spec(8'h00);
    step("t2", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'b0010, 1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2.ghr_const", {24'h0, bus_if.GHR_history_o}, 32'h01);

    set_spec(8'hA5);
    step("t3", 1'b1, 1'b1, 4'hF, 4'b0101, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3.ghr_const", {24'h0, bus_if.GHR_history_o}, 32'h94);

    // Jump in slot 1 squashes slots 2-3.
    set_spec(8'h0F);
    step("jump", 1'b1, 1'b1, 4'hF, 4'b1101, 4'b0010, 4'b1100, 1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0);
    chk("jump.ghr_const", {24'h0, bus_if.GHR_history_o}, 32'h1E);

    // No fire without index_ok.
    step("nofire", 1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0);

    step("t4a", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 8'h3C, 1'b1, 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4a.ghr_const", {24'h0, bus_if.GHR_history_o}, 32'h79);
    step("t4b", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 8'h3C, 1'b0, 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4b.ghr_const", {24'h0, bus_if.GHR_history_o}, 32'h3C);

    // Build archGHR = 0x81 by retiring bits MSB first.
    mdl_arch = 8'h00;
    arch_pat = 8'h81;
    for (int k = 7; k >= 0; k--) retire(arch_pat[k]);
    step("t5", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 8'h3C, 1'b1, 1'b1,
         1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5.ghr_const", {24'h0, bus_if.GHR_history_o}, 32'h02);
    set_spec(8'h77);
    step("t5.arch", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5.arch_const", {24'h0, bus_if.GHR_history_o}, 32'h02);

    for (int k = 0; k < 16; k++)
      step("t6", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.ghr_const", {24'h0, bus_if.GHR_history_o}, 32'hFF);

    for (int k = 0; k < 60; k++)
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)), 4'($urandom),
           1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));

    // Asynchronous reset away from any clock edge.
    set_spec(8'hC3);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("areset.ghr", {24'h0, bus_if.GHR_history_o}, 32'h0);
    chk("areset.slots", bus_if.GHR_slotHist_p_o, 32'h0);
    mdl_spec = 8'h00;
    mdl_arch = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    step("post_rst.flush", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
